// File: rtl/csa_pkg.sv
// Shared definitions for the conditional-sum adder.
//   CSA_DEFAULT_WIDTH : default operand width
//   clog2             : ceiling log2, used to size the merge tree
//   csa_pair_t        : one candidate {sum, carry} pair at the default width
package csa_pkg;

  localparam int CSA_DEFAULT_WIDTH = 8;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  typedef struct packed {
    logic [CSA_DEFAULT_WIDTH-1:0] sum;
    logic                         carry;
  } csa_pair_t;

endpackage

// File: rtl/conditional_sum_adder_if.sv
// Operand/result bundle for conditional_sum_adder.
//   in_valid, a, b            : operand side (driven by master)
//   out_valid, sum, carry_out : result side (driven by slave)
interface conditional_sum_adder_if
  import csa_pkg::*;
#(
  parameter int WIDTH = CSA_DEFAULT_WIDTH
);
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic [WIDTH-1:0] sum;
  logic             carry_out;

  modport master (output in_valid, a, b, input out_valid, sum, carry_out);
  modport slave  (input in_valid, a, b, output out_valid, sum, carry_out);
endinterface

// File: rtl/csa_merge_cell.sv
// One node of the conditional-sum tree: merges two adjacent BLK-bit blocks
// into a 2*BLK-bit block, for both carry-in assumptions (0 and 1).
//   s0_lo/c0_lo, s1_lo/c1_lo : lower block pairs (carry-in 0 / carry-in 1)
//   s0_hi/c0_hi, s1_hi/c1_hi : upper block pairs (carry-in 0 / carry-in 1)
//   s0/c0, s1/c1             : merged pairs (carry-in 0 / carry-in 1)
module csa_merge_cell
  import csa_pkg::*;
#(
  parameter int BLK = 1
) (
  input  logic [BLK-1:0]   s0_lo,
  input  logic [BLK-1:0]   s1_lo,
  input  logic             c0_lo,
  input  logic             c1_lo,
  input  logic [BLK-1:0]   s0_hi,
  input  logic [BLK-1:0]   s1_hi,
  input  logic             c0_hi,
  input  logic             c1_hi,
  output logic [2*BLK-1:0] s0,
  output logic [2*BLK-1:0] s1,
  output logic             c0,
  output logic             c1
);

  // The lower block's carry under each assumption picks which of the upper
  // block's precomputed pairs is the true one; lower sums pass straight up.
  assign s0 = {(c0_lo ? s1_hi : s0_hi), s0_lo};
  assign c0 = c0_lo ? c1_hi : c0_hi;
  assign s1 = {(c1_lo ? s1_hi : s0_hi), s1_lo};
  assign c1 = c1_lo ? c1_hi : c0_hi;

endmodule

// File: rtl/conditional_sum_adder.sv
// Unsigned WIDTH-bit conditional-sum adder with registered result.
// {carry_out, sum} = a + b (carry-in 0), one cycle after the operands are
// sampled. Optional macro CSA_IN_REG_EN adds an input register stage,
// making the latency two cycles.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset (clears valid and result)
//   bus : slave side of conditional_sum_adder_if
//         (in_valid, a, b in; out_valid, sum, carry_out out)
module conditional_sum_adder
  import csa_pkg::*;
#(
  parameter int WIDTH = CSA_DEFAULT_WIDTH
) (
  input logic                   clk,
  input logic                   rst,
  conditional_sum_adder_if.slave bus
);

  localparam int LEVELS = clog2(WIDTH);

  if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("conditional_sum_adder: WIDTH must be a power of two >= 2");
  end

  logic             vld_p0;
  logic [WIDTH-1:0] a_p0;
  logic [WIDTH-1:0] b_p0;

  // ---- stage p0: operands entering the combinational tree ----
`ifdef CSA_IN_REG_EN
  // Operands are only loaded when valid, so X on an idle bus never enters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      a_p0   <= '0;
      b_p0   <= '0;
    end else begin
      vld_p0 <= bus.in_valid;
      if (bus.in_valid) begin
        a_p0 <= bus.a;
        b_p0 <= bus.b;
      end
    end
  end
`else
  assign vld_p0 = bus.in_valid;
  assign a_p0   = bus.a;
  assign b_p0   = bus.b;
`endif

  // Level k holds WIDTH>>k blocks of 2^k bits, each with a pair per
  // carry-in assumption; level LEVELS is a single full-width block.
  for (genvar k = 0; k <= LEVELS; k++) begin : lvl
    localparam int NB  = WIDTH >> k;
    localparam int BLK = 1 << k;
    logic [WIDTH-1:0] s0;
    logic [WIDTH-1:0] s1;
    logic [NB-1:0]    c0;
    logic [NB-1:0]    c1;

    if (k == 0) begin : leaf
      assign s0 = a_p0 ^ b_p0;
      assign c0 = a_p0 & b_p0;
      assign s1 = ~(a_p0 ^ b_p0);
      assign c1 = a_p0 | b_p0;
    end else begin : mrg
      localparam int HB = BLK / 2;
      for (genvar j = 0; j < NB; j++) begin : blk
        csa_merge_cell #(.BLK(HB)) u_cell (
          .s0_lo (lvl[k-1].s0[(2*j)*HB +: HB]),
          .s1_lo (lvl[k-1].s1[(2*j)*HB +: HB]),
          .c0_lo (lvl[k-1].c0[2*j]),
          .c1_lo (lvl[k-1].c1[2*j]),
          .s0_hi (lvl[k-1].s0[(2*j+1)*HB +: HB]),
          .s1_hi (lvl[k-1].s1[(2*j+1)*HB +: HB]),
          .c0_hi (lvl[k-1].c0[2*j+1]),
          .c1_hi (lvl[k-1].c1[2*j+1]),
          .s0    (s0[j*BLK +: BLK]),
          .s1    (s1[j*BLK +: BLK]),
          .c0    (c0[j]),
          .c1    (c1[j])
        );
      end
    end
  end

  // ---- stage p1: output register ----
  logic             vld_p1;
  logic [WIDTH-1:0] sum_p1;
  logic             cry_p1;

  // Result only loads on valid, so it holds steady (no toggling) when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      sum_p1 <= '0;
      cry_p1 <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        sum_p1 <= lvl[LEVELS].s0;
        cry_p1 <= lvl[LEVELS].c0[0];
      end
    end
  end

  assign bus.out_valid = vld_p1;
  assign bus.sum       = sum_p1;
  assign bus.carry_out = cry_p1;

endmodule

// File: tb/tb_conditional_sum_adder.sv
// Self-checking bench for conditional_sum_adder: an 8-bit and a 16-bit
// instance, a per-cycle reference model of each, and literal vectors.
module tb_conditional_sum_adder;

`ifdef CSA_IN_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  conditional_sum_adder_if #(.WIDTH(8))  bus8 ();
  conditional_sum_adder_if #(.WIDTH(16)) bus16 ();

  conditional_sum_adder #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));
  conditional_sum_adder #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic        v;
    logic [16:0] r;
  } ent_t;

  ent_t        q8[$];
  ent_t        q16[$];
  ent_t        e8;
  ent_t        e16;
  logic        m8_v,  m16_v;
  logic [8:0]  m8_r;
  logic [16:0] m16_r;

  // Each edge enqueues what was presented; the entry LAT edges old becomes
  // the visible result. Invalid entries leave the result unchanged.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q8  = {};
      q16 = {};
      for (int i = 0; i < LAT - 1; i++) begin
        q8.push_back('0);
        q16.push_back('0);
      end
      m8_v  = 1'b0;
      m8_r  = '0;
      m16_v = 1'b0;
      m16_r = '0;
    end else begin
      e8.v  = bus8.in_valid;
      e8.r  = bus8.in_valid ? (17'(bus8.a) + 17'(bus8.b)) : '0;
      e16.v = bus16.in_valid;
      e16.r = bus16.in_valid ? (17'(bus16.a) + 17'(bus16.b)) : '0;
      q8.push_back(e8);
      q16.push_back(e16);
      e8  = q8.pop_front();
      e16 = q16.pop_front();
      m8_v  = e8.v;
      m16_v = e16.v;
      if (e8.v)  m8_r  = e8.r[8:0];
      if (e16.v) m16_r = e16.r;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: outputs are always meaningful outside reset.
  always @(negedge clk) begin
    if (!rst) begin
      chk("model8_valid", 32'(bus8.out_valid), 32'(m8_v));
      chk("model8_result", 32'({bus8.carry_out, bus8.sum}), 32'(m8_r));
      chk("model16_valid", 32'(bus16.out_valid), 32'(m16_v));
      chk("model16_result", 32'({bus16.carry_out, bus16.sum}), 32'(m16_r));
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_result();
    if (LAT > 1) begin
      repeat (LAT - 1) @(posedge clk);
      #1;
    end
  endtask

  task automatic send8(input logic [7:0] x, input logic [7:0] y);
    @(posedge clk); #1;
    bus8.in_valid = 1'b1; bus8.a = x; bus8.b = y;
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    wait_result();
  endtask

  task automatic send16(input logic [15:0] x, input logic [15:0] y);
    @(posedge clk); #1;
    bus16.in_valid = 1'b1; bus16.a = x; bus16.b = y;
    @(posedge clk); #1;
    bus16.in_valid = 1'b0;
    wait_result();
  endtask

  task automatic lit8(input string name, input logic [7:0] x, input logic [7:0] y,
                      input logic [7:0] s, input logic c);
    send8(x, y);
    chk({name, "_sum"}, 32'(bus8.sum), 32'(s));
    chk({name, "_cout"}, 32'(bus8.carry_out), 32'(c));
    chk({name, "_valid"}, 32'(bus8.out_valid), 32'd1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    bus8.in_valid = 1'b0;  bus8.a = '0;  bus8.b = '0;
    bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("reset_sum", 32'(bus8.sum), 32'h0);
    chk("reset_cout", 32'(bus8.carry_out), 32'h0);
    chk("reset_valid", 32'(bus8.out_valid), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    lit8("zero",  8'h00, 8'h00, 8'h00, 1'b0);
    lit8("basic", 8'h0F, 8'h01, 8'h10, 1'b0);
    lit8("ripple", 8'hFF, 8'h01, 8'h00, 1'b1);
    lit8("allones", 8'hFF, 8'hFF, 8'hFE, 1'b1);
    lit8("msb", 8'h80, 8'h80, 8'h00, 1'b1);

    // Hold: idle bus (including X operands) must not disturb the result.
    lit8("hold_pre", 8'h12, 8'h34, 8'h46, 1'b0);
    bus8.a = 8'hFF; bus8.b = 8'hFF;
    repeat (2) @(posedge clk); #1;
    chk("hold_sum", 32'(bus8.sum), 32'h46);
    chk("hold_cout", 32'(bus8.carry_out), 32'h0);
    chk("hold_valid", 32'(bus8.out_valid), 32'h0);
    bus8.a = 'x; bus8.b = 'x;
    repeat (3) @(posedge clk); #1;
    chk("xhold_sum", 32'(bus8.sum), 32'h46);
    chk("xhold_cout", 32'(bus8.carry_out), 32'h0);
    bus8.a = '0; bus8.b = '0;

    // Mid-run asynchronous reset with nonzero outputs.
    lit8("pre_reset", 8'hFF, 8'hFF, 8'hFE, 1'b1);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("async_rst_sum", 32'(bus8.sum), 32'h0);
    chk("async_rst_cout", 32'(bus8.carry_out), 32'h0);
    chk("async_rst_valid", 32'(bus8.out_valid), 32'h0);
    @(posedge clk); #1 rst = 1'b0;

    // 16-bit instance.
    send16(16'hFFFF, 16'h0001);
    chk("w16_ripple_sum", 32'(bus16.sum), 32'h0000);
    chk("w16_ripple_cout", 32'(bus16.carry_out), 32'h1);
    send16(16'h7FFF, 16'h7FFF);
    chk("w16_half_sum", 32'(bus16.sum), 32'hFFFE);
    chk("w16_half_cout", 32'(bus16.carry_out), 32'h0);

    // Exhaustive 8-bit sweep, back-to-back; checked by the compare process.
    for (int i = 0; i < 256; i++) begin
      for (int j = 0; j < 256; j++) begin
        @(posedge clk); #1;
        bus8.in_valid = 1'b1;
        bus8.a = 8'(i);
        bus8.b = 8'(j);
      end
    end
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    repeat (LAT + 1) @(posedge clk);
    #1;
    chk("sweep_last_sum", 32'(bus8.sum), 32'hFE);
    chk("sweep_last_cout", 32'(bus8.carry_out), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
